event_monitor: RTL and testbench

EVENT_MONITOR -- requirements
Module: event_monitor

---
 rtl/event_monitor.sv | 85 ++++++++
 tb/tb_event_monitor.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/event_monitor.sv
// Change/strobe event monitor: timestamps channel activity and queues
// {strobe, timestamp, signals} records in a first-word-fall-through FIFO.
module event_monitor #(
    parameter int unsigned NCH   = 3,
    parameter int unsigned TSW   = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     strobe,
    input  logic [NCH-1:0]           sig,
    input  logic                     rd_en,
    input  logic                     clr_ovf,
    output logic                     rd_valid,
    output logic [TSW+NCH:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned RW = 1 + TSW + NCH;

    logic [TSW-1:0] tcnt_q, tcnt_d;
    logic [NCH-1:0] prev_q;
    logic           primed_q, primed_d;
    logic [AW-1:0]  wptr_q, wptr_d;
    logic [AW-1:0]  rptr_q, rptr_d;
    logic [AW:0]    count_q, count_d;
    logic           ovf_q, ovf_d;
    logic [RW-1:0]  mem_q [DEPTH];

    logic evt, pop, full, wr, drop;

    always_comb begin
        evt  = en && (strobe || (sig != prev_q) || !primed_q);
        pop  = rd_en && (count_q != '0);
        full = (count_q == (AW+1)'(DEPTH));
        // A full FIFO still accepts a write when the head leaves on the same edge.
        wr   = evt && (!full || pop);
        drop = evt && full && !pop;

        tcnt_d   = tcnt_q + 1'b1;
        primed_d = primed_q | en;
        wptr_d   = wr  ? wptr_q + 1'b1 : wptr_q;
        rptr_d   = pop ? rptr_q + 1'b1 : rptr_q;
        count_d  = count_q + (AW+1)'(wr) - (AW+1)'(pop);
        ovf_d    = drop | (ovf_q & ~clr_ovf);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt_q   <= '0;
            prev_q   <= '0;
            primed_q <= 1'b0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            tcnt_q   <= tcnt_d;
            prev_q   <= sig;
            primed_q <= primed_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is not reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem_q[wptr_q] <= {strobe, tcnt_q, sig};
        end
    end

    always_comb begin
        rd_valid = (count_q != '0);
        rd_data  = rd_valid ? mem_q[rptr_q] : '0;
        count    = count_q;
        overflow = ovf_q;
    end

endmodule

// File: tb/tb_event_monitor.sv
// Directed table-driven bench for event_monitor (NCH=3, TSW=8, DEPTH=4).
module tb_event_monitor;

    localparam int unsigned NCH   = 3;
    localparam int unsigned TSW   = 8;
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0, strobe = 1'b0, rd_en = 1'b0, clr_ovf = 1'b0;
    logic [2:0]  sig = 3'b000;
    logic        rd_valid;
    logic [11:0] rd_data;
    logic [2:0]  count;
    logic        overflow;

    event_monitor #(.NCH(NCH), .TSW(TSW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .strobe   (strobe),
        .sig      (sig),
        .rd_en    (rd_en),
        .clr_ovf  (clr_ovf),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .count    (count),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en, strb;
        logic [2:0]  sg;
        logic        rd, clr;
        logic        v;
        logic [11:0] data;
        logic [2:0]  cnt;
        logic        ovf;
    } vec_t;

    vec_t vq[$];
    int   passed = 0;
    int   total  = 0;

    function automatic logic [11:0] rec(input logic s, input int ts, input logic [2:0] sg);
        logic [7:0] t;
        t = ts[7:0];
        return {s, t, sg};
    endfunction

    task automatic add(input logic e, input logic st, input logic [2:0] sg, input logic rd,
                       input logic cl, input logic v, input logic [11:0] d,
                       input logic [2:0] c, input logic o);
        vec_t x;
        x.en = e; x.strb = st; x.sg = sg; x.rd = rd; x.clr = cl;
        x.v = v; x.data = d; x.cnt = c; x.ovf = o;
        vq.push_back(x);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic chk_all(input string tag, input logic v, input logic [11:0] d,
                           input logic [2:0] c, input logic o);
        chk({tag, ".valid"}, 32'(rd_valid), 32'(v));
        chk({tag, ".data"},  32'(rd_data),  32'(d));
        chk({tag, ".count"}, 32'(count),    32'(c));
        chk({tag, ".ovf"},   32'(overflow), 32'(o));
    endtask

    // Caller sits at a negedge; drive, take one rising edge, sample 1ns later.
    task automatic step(input logic e, input logic st, input logic [2:0] sg,
                        input logic rd, input logic cl);
        en = e; strobe = st; sig = sg; rd_en = rd; clr_ovf = cl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // edges 0..4: priming record then change records at ts 3 and 4
        add(1,0,3'b000,0,0, 1,rec(0,0,0),1,0);
        add(1,0,3'b000,0,0, 1,rec(0,0,0),1,0);
        add(1,0,3'b000,0,0, 1,rec(0,0,0),1,0);
        add(1,0,3'b001,0,0, 1,rec(0,0,0),2,0);
        add(1,0,3'b000,0,0, 1,rec(0,0,0),3,0);
        add(1,0,3'b000,1,0, 1,rec(0,3,1),2,0);
        add(1,0,3'b000,1,0, 1,rec(0,4,0),1,0);
        add(1,0,3'b000,1,0, 0,12'h000,0,0);
        add(1,0,3'b000,1,0, 0,12'h000,0,0);       // read while empty ignored
        add(1,0,3'b101,0,0, 1,rec(0,9,5),1,0);
        add(1,1,3'b101,1,0, 1,rec(1,10,5),1,0);   // strobe, sig unchanged
        add(1,1,3'b110,1,0, 1,rec(1,11,6),1,0);   // strobe + change -> one record
        add(1,0,3'b110,1,0, 0,12'h000,0,0);
        // edges 13..18: six events into depth 4
        for (int i = 0; i < 6; i++)
            add(1,1,3'b110,0,0, 1,rec(1,13,6),(i < 4) ? 3'(i+1) : 3'd4, (i >= 4));
        add(1,0,3'b110,0,1, 1,rec(1,13,6),4,0);
        add(1,1,3'b110,1,0, 1,rec(1,14,6),4,0);   // full: write + pop same edge
        add(1,0,3'b110,1,0, 1,rec(1,15,6),3,0);
        add(1,0,3'b110,1,0, 1,rec(1,16,6),2,0);
        add(1,0,3'b110,1,0, 1,rec(1,20,6),1,0);
        add(1,0,3'b110,1,0, 0,12'h000,0,0);
        // edges 25..30: refill, drop with clr_ovf on the same edge (set wins)
        for (int i = 0; i < 4; i++)
            add(1,1,3'b110,0,0, 1,rec(1,25,6),3'(i+1),0);
        add(1,1,3'b110,0,1, 1,rec(1,25,6),4,1);
        add(1,0,3'b110,0,1, 1,rec(1,25,6),4,0);
        add(1,0,3'b110,1,0, 1,rec(1,26,6),3,0);
        add(1,0,3'b110,1,0, 1,rec(1,27,6),2,0);
        add(1,0,3'b110,1,0, 1,rec(1,28,6),1,0);
        add(1,0,3'b110,1,0, 0,12'h000,0,0);
        // edges 35..38: change while disabled is never recorded later
        add(0,0,3'b011,0,0, 0,12'h000,0,0);
        add(1,0,3'b011,0,0, 0,12'h000,0,0);
        add(1,0,3'b000,1,0, 1,rec(0,37,0),1,0);   // rd_en while empty + write
        add(1,0,3'b000,1,0, 0,12'h000,0,0);

        #12;
        chk_all("reset", 0, 12'h000, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        foreach (vq[i]) begin
            step(vq[i].en, vq[i].strb, vq[i].sg, vq[i].rd, vq[i].clr);
            chk_all($sformatf("vec%0d", i), vq[i].v, vq[i].data, vq[i].cnt, vq[i].ovf);
            @(negedge clk);
        end

        // timestamp wrap: quiet up to ts 254, then changes at 255 and 0
        for (int e = 39; e < 255; e++) begin
            step(1, 0, 3'b000, 0, 0);
            @(negedge clk);
        end
        chk("quiet.count", 32'(count), 32'd0);
        step(1, 0, 3'b001, 0, 0);
        chk_all("wrap255", 1, rec(0,255,1), 1, 0);
        @(negedge clk);
        step(1, 0, 3'b010, 0, 0);
        chk_all("wrap0", 1, rec(0,255,1), 2, 0);
        @(negedge clk);
        step(1, 0, 3'b010, 1, 0);
        chk_all("wrap.pop", 1, rec(0,0,2), 1, 0);

        // asynchronous reset mid-cycle discards contents at once
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("midreset", 0, 12'h000, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 3'b000, 0, 0);
        chk_all("reprime", 1, rec(0,0,0), 1, 0);
        @(negedge clk);
        step(1, 0, 3'b000, 0, 0);
        chk_all("reprime.quiet", 1, rec(0,0,0), 1, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
